readpixel: RTL

READPIXEL -- requirements
Module: readpixel

---
 rtl/readpixel_pkg.sv | 27 ++
 rtl/pixel_sync.sv | 23 ++
 rtl/readpixel.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/readpixel_pkg.sv
// Shared definitions for the single-wire pixel receiver and transmitter.
//   - rx_state_e  : receiver FSM state encodings
//   - pixel_t     : 24-bit pixel word layout {r, g, b}; r[7] is sent first
//   - ns_to_cycles: ceil(ns * clk_hz / 1e9), used to derive cycle thresholds
package readpixel_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LATCH = 3'd0,
        ST_IDLE       = 3'd1,
        ST_HIGH       = 3'd2,
        ST_LOW        = 3'd3,
        ST_FORWARD    = 3'd4
    } rx_state_e;

    localparam int PIXEL_BITS = 32'd24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    function automatic int ns_to_cycles(input longint ns, input longint clk_hz);
        return int'((ns * clk_hz + 64'sd999_999_999) / 64'sd1_000_000_000);
    endfunction

endpackage

// File: rtl/pixel_sync.sv
// Two-flop synchronizer for the asynchronous pixel stream.
// Ports: clk, reset (sync, active-high), d_in (async), s (synchronized level).
module pixel_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic s
);

    logic meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            s      <= 1'b0;
        end else begin
            meta_r <= d_in;
            s      <= meta_r;
        end
    end

endmodule

// File: rtl/readpixel.sv
// Single-wire pixel stream receiver. Decodes the first 24-bit pixel of each
// frame from pulse-width coded highs, then forwards the rest of the stream.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   d_in                  : asynchronous stream input
//   pixel_r/g/b           : last decoded pixel, updated with valid
//   valid                 : one-cycle pulse per decoded first pixel
//   frame_end             : one-cycle pulse on latch (long low) detection
//   d_out                 : stream pass-through while forwarding, else 0
//   busy                  : high while a frame is in progress
//   error                 : one-cycle pulse on a protocol violation
module readpixel
    import readpixel_pkg::*;
#(
    parameter int clk_in_rate_hz = 32'd12_000_000,
    parameter int t1_min_ns      = 32'd600,
    parameter int glitch_max_ns  = 32'd150,
    parameter int high_max_ns    = 32'd2000,
    parameter int reset_min_ns   = 32'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_in,
    output logic [7:0] pixel_r,
    output logic [7:0] pixel_g,
    output logic [7:0] pixel_b,
    output logic       valid,
    output logic       frame_end,
    output logic       d_out,
    output logic       busy,
    output logic       error
);

    localparam int T1_MIN    = ns_to_cycles(longint'(t1_min_ns),    longint'(clk_in_rate_hz));
    localparam int GLITCH    = ns_to_cycles(longint'(glitch_max_ns), longint'(clk_in_rate_hz));
    localparam int HIGH_MAX  = ns_to_cycles(longint'(high_max_ns),   longint'(clk_in_rate_hz));
    localparam int RESET_MIN = ns_to_cycles(longint'(reset_min_ns),  longint'(clk_in_rate_hz));

    localparam int HCW = ($clog2(HIGH_MAX + 2) > 5)  ? $clog2(HIGH_MAX + 2)  : 5;
    localparam int LCW = ($clog2(RESET_MIN + 1) > 10) ? $clog2(RESET_MIN + 1) : 10;

    localparam logic [HCW-1:0] T1_MIN_C    = HCW'(T1_MIN);
    localparam logic [HCW-1:0] GLITCH_C    = HCW'(GLITCH);
    localparam logic [HCW-1:0] HIGH_MAX_C  = HCW'(HIGH_MAX);
    localparam logic [HCW-1:0] HIGH_SAT_C  = HCW'(HIGH_MAX + 1);
    localparam logic [LCW-1:0] RESET_MIN_C = LCW'(RESET_MIN);
    localparam logic [LCW-1:0] LOW_LAST_C  = LCW'(RESET_MIN - 1);
    localparam logic [4:0]     BIT_LAST_C  = 5'(PIXEL_BITS - 1);

    logic           sync_r;
    logic           sync_d_r;
    logic           rise_s;
    logic           fall_s;
    logic           latch_s;
    logic [HCW-1:0] high_cnt_r;
    logic [LCW-1:0] low_cnt_r;
    rx_state_e      state_r;
    rx_state_e      state_s;
    pixel_t         shift_r;
    pixel_t         shift_s;
    logic [4:0]     bit_idx_r;
    logic [4:0]     bit_idx_s;
    logic           load_s;
    logic           load_r;
    logic           load_d_r;
    logic           fe_s;
    logic           err_s;

    pixel_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .s     (sync_r)
    );

    assign rise_s  = sync_r & ~sync_d_r;
    assign fall_s  = ~sync_r & sync_d_r;
    // Fires on the edge that completes the RESET_MIN-th low cycle, so the
    // FSM is already idle when a rise immediately follows the latch.
    assign latch_s = ~sync_r & (low_cnt_r == LOW_LAST_C);

    // Edge-detect delay plus saturating high/low duration counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_d_r   <= 1'b0;
            high_cnt_r <= '0;
            low_cnt_r  <= '0;
        end else begin
            sync_d_r <= sync_r;
            if (sync_r) begin
                low_cnt_r <= '0;
                if (high_cnt_r != HIGH_SAT_C) begin
                    high_cnt_r <= high_cnt_r + {{(HCW-1){1'b0}}, 1'b1};
                end
            end else begin
                high_cnt_r <= '0;
                if (low_cnt_r != RESET_MIN_C) begin
                    low_cnt_r <= low_cnt_r + {{(LCW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Next-state, bit shifting and pulse requests for the receive FSM.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_idx_s = bit_idx_r;
        load_s    = 1'b0;
        fe_s      = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_WAIT_LATCH: begin
                if (latch_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_LATCH;
                end
            end
            ST_IDLE: begin
                if (rise_s) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (high_cnt_r > HIGH_MAX_C) begin
                    err_s     = 1'b1;
                    bit_idx_s = 5'd0;
                    state_s   = ST_WAIT_LATCH;
                end else if (fall_s) begin
                    if (high_cnt_r <= GLITCH_C) begin
                        err_s   = 1'b1;
                        state_s = ST_LOW;
                    end else begin
                        shift_s = pixel_t'({shift_r[PIXEL_BITS-2:0], (high_cnt_r >= T1_MIN_C)});
                        if (bit_idx_r == BIT_LAST_C) begin
                            load_s    = 1'b1;
                            bit_idx_s = 5'd0;
                            state_s   = ST_FORWARD;
                        end else begin
                            bit_idx_s = bit_idx_r + 5'd1;
                            state_s   = ST_LOW;
                        end
                    end
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (latch_s) begin
                    // A frame that ends with a partial pixel is a violation.
                    if (bit_idx_r != 5'd0) begin
                        fe_s  = 1'b1;
                        err_s = 1'b1;
                    end else begin
                        fe_s  = 1'b0;
                    end
                    bit_idx_s = 5'd0;
                    state_s   = ST_IDLE;
                end else if (rise_s) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_FORWARD: begin
                if (high_cnt_r > HIGH_MAX_C) begin
                    err_s   = 1'b1;
                    state_s = ST_WAIT_LATCH;
                end else if (latch_s) begin
                    fe_s    = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FORWARD;
                end
            end
            default: begin
                bit_idx_s = 5'd0;
                state_s   = ST_WAIT_LATCH;
            end
        endcase
    end

    // FSM registers and registered status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_WAIT_LATCH;
            shift_r   <= '0;
            bit_idx_r <= 5'd0;
            load_r    <= 1'b0;
            frame_end <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_idx_r <= bit_idx_s;
            load_r    <= load_s;
            frame_end <= fe_s;
            error     <= err_s;
            busy      <= (state_s == ST_HIGH) || (state_s == ST_LOW) || (state_s == ST_FORWARD);
        end
    end

    // Pixel output load, with valid following one cycle after the load so
    // that valid lands four clocks after the closing low is first sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_r  <= 8'd0;
            pixel_g  <= 8'd0;
            pixel_b  <= 8'd0;
            load_d_r <= 1'b0;
            valid    <= 1'b0;
        end else begin
            if (load_r) begin
                pixel_r <= shift_r.r;
                pixel_g <= shift_r.g;
                pixel_b <= shift_r.b;
            end
            load_d_r <= load_r;
            valid    <= load_d_r;
        end
    end

    // The first pixel is consumed; only the remainder of the frame is passed on.
    assign d_out = sync_r & (state_r == ST_FORWARD);

endmodule
